sram_req_arbiter: RTL

// - Shares one SRAM-like memory port between the IF-stage instruction master and the MEM-stage data master.
// - Both masters use the req/addr_ok/data_ok split-transaction protocol.
// - Arbitrates address phases and keeps an in-order ID queue of accepted requests.
// - Routes each returning data_ok/rdata to the master that issued the request.
// - Sits between the CPU core and the single cache/bridge port.

---
 rtl/sram_req_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like split-transaction port between the IF (inst) and MEM (data) masters.
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed data>inst priority.
module sram_req_arbiter #(
  parameter int OUTSTD = 4,
  parameter int IDX_W  = 2
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        err_unexp_ok
);

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(OUTSTD);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state;
  logic              r_holdId;
  logic [OUTSTD-1:0] r_idQ;
  logic [IDX_W-1:0]  r_wrPtr;
  logic [IDX_W-1:0]  r_rdPtr;
  logic [IDX_W:0]    r_count;
  logic              r_err;

  logic w_full;
  logic w_empty;
  logic w_arbGrant;
  logic w_grant;
  logic w_memReq;
  logic w_accept;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

`ifdef SRAM_ARB_RR_EN
  logic r_lastGrant;

  // On contention the master that did not win the previous accept goes first.
  always_comb begin
    if (inst_req && data_req) w_arbGrant = ~r_lastGrant;
    else                      w_arbGrant = data_req;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_lastGrant <= ID_INST;
    else if (w_accept) r_lastGrant <= w_grant;
  end
`else
  assign w_arbGrant = data_req;
`endif

  assign w_grant  = (r_state == HOLD) ? r_holdId : w_arbGrant;
  assign w_memReq = resetn && !w_full && ((r_state == HOLD) || inst_req || data_req);
  assign w_accept = w_memReq && mem_addr_ok;
  assign w_pop    = resetn && mem_data_ok && !w_empty;
  assign w_head   = r_idQ[r_rdPtr];

  assign mem_req   = w_memReq;
  assign mem_wr    = resetn && ((w_grant == ID_DATA) ? data_wr : inst_wr);
  assign mem_size  = !resetn ? 2'd0  : ((w_grant == ID_DATA) ? data_size  : inst_size);
  assign mem_addr  = !resetn ? 32'd0 : ((w_grant == ID_DATA) ? data_addr  : inst_addr);
  assign mem_wdata = !resetn ? 32'd0 : ((w_grant == ID_DATA) ? data_wdata : inst_wdata);

  assign inst_addr_ok = w_accept && (w_grant == ID_INST);
  assign data_addr_ok = w_accept && (w_grant == ID_DATA);
  assign inst_data_ok = w_pop && (w_head == ID_INST);
  assign data_data_ok = w_pop && (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_unexp_ok = r_err;

  // A stalled address phase locks the grant until the shared port finally accepts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_holdId <= ID_INST;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memReq && !mem_addr_ok) begin
            r_state  <= HOLD;
            r_holdId <= w_grant;
          end
        end
        HOLD: begin
          if (w_accept) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idQ   <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idQ[r_wrPtr] <= w_grant;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
      // A response with nothing outstanding is a protocol error that stays flagged.
      if (mem_data_ok && w_empty) r_err <= 1'b1;
    end
  end

endmodule
